// File: rtl/shift_count_register.sv
//------------------------------------------------------------------------------
// Module   : shift_count_register
// Brief    : Parametrised load/count/shift register with carry/zero flags
//            and multi-cycle shifts under a busy/done handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_count_register #(
    parameter int WIDTH   = 4,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cl,
    input  logic               ld,
    input  logic [WIDTH-1:0]   in,
    input  logic               inc,
    input  logic               dec,
    input  logic               sr,
    input  logic               sl,
    input  logic               ir,
    input  logic               il,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               rot,
    input  logic               sat,
    output logic [WIDTH-1:0]   out,
    output logic               carry,
    output logic               zero,
    output logic               busy,
    output logic               done
);

    localparam logic [WIDTH-1:0]   c_ones = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   c_zero = '0;
    localparam logic [SHAMT_W-1:0] c_cnt_zero = '0;
    localparam logic [SHAMT_W-1:0] c_cnt_one  = SHAMT_W'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_out, w_out_nxt;
    logic               r_carry, w_carry_nxt;
    logic               r_done, w_done_nxt;
    logic [SHAMT_W-1:0] r_cnt, w_cnt_nxt;
    logic               r_left, w_left_nxt;
    logic               r_rot, w_rot_nxt;
    logic [WIDTH:0]     w_step;

    // One shift step: returns {shifted-out bit, new value}
    function automatic logic [WIDTH:0] f_step(
        input logic [WIDTH-1:0] v,
        input logic             left,
        input logic             rotate,
        input logic             fill_r,
        input logic             fill_l
    );
        logic fill;
        if (left) begin
            fill = rotate ? v[WIDTH-1] : fill_l;
            return {v[WIDTH-1], v[WIDTH-2:0], fill};
        end else begin
            fill = rotate ? v[0] : fill_r;
            return {v[0], fill, v[WIDTH-1:1]};
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_out   <= '0;
            r_carry <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_left  <= 1'b0;
            r_rot   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_carry <= w_carry_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
            r_left  <= w_left_nxt;
            r_rot   <= w_rot_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_carry_nxt = r_carry;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_left_nxt  = r_left;
        w_rot_nxt   = r_rot;
        w_step      = '0;

        case (r_state)
            IDLE: begin
                if (cl) begin
                    w_out_nxt   = '0;
                    w_carry_nxt = 1'b0;
                end else if (ld) begin
                    w_out_nxt = in;
                end else if (inc) begin
                    if (r_out == c_ones) begin
                        w_out_nxt   = sat ? r_out : c_zero;
                        w_carry_nxt = 1'b1;
                    end else begin
                        w_out_nxt   = r_out + WIDTH'(1);
                        w_carry_nxt = 1'b0;
                    end
                end else if (dec) begin
                    if (r_out == c_zero) begin
                        w_out_nxt   = sat ? r_out : c_ones;
                        w_carry_nxt = 1'b1;
                    end else begin
                        w_out_nxt   = r_out - WIDTH'(1);
                        w_carry_nxt = 1'b0;
                    end
                end else if ((sr || sl) && (shamt != c_cnt_zero)) begin
                    // First step happens on the accepting edge; sr wins over sl
                    w_step      = f_step(r_out, !sr, rot, ir, il);
                    w_out_nxt   = w_step[WIDTH-1:0];
                    w_carry_nxt = w_step[WIDTH];
                    w_left_nxt  = !sr;
                    w_rot_nxt   = rot;
                    w_cnt_nxt   = shamt - c_cnt_one;
                    if (shamt == c_cnt_one) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (cl) begin
                    w_out_nxt   = '0;
                    w_carry_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_step      = f_step(r_out, r_left, r_rot, ir, il);
                    w_out_nxt   = w_step[WIDTH-1:0];
                    w_carry_nxt = w_step[WIDTH];
                    w_cnt_nxt   = r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign out   = r_out;
    assign carry = r_carry;
    assign zero  = (r_out == c_zero);
    assign busy  = (r_state == SHIFT);
    assign done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_shift_count_register.sv
//------------------------------------------------------------------------------
// Module   : tb_shift_count_register
// Brief    : Directed vector table plus multi-cycle sequences for the
//            shift/count register (WIDTH=4, SHAMT_W=3).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_count_register;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cl, ld, inc, dec, sr, sl, ir, il, rot, sat;
    logic [3:0] in;
    logic [2:0] shamt;
    logic [3:0] out;
    logic       carry, zero, busy, done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_count_register #(.WIDTH(4), .SHAMT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .in(in), .inc(inc),
        .dec(dec), .sr(sr), .sl(sl), .ir(ir), .il(il), .shamt(shamt),
        .rot(rot), .sat(sat), .out(out), .carry(carry), .zero(zero),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic       cl, ld, inc, dec, sr, sl, ir, il, rot, sat;
        logic [2:0] shamt;
        logic [3:0] din;
        logic [3:0] e_out;
        logic       e_carry, e_busy, e_done;
    } vec_t;

    vec_t vec[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cl = 0; ld = 0; inc = 0; dec = 0; sr = 0; sl = 0;
        ir = 0; il = 0; rot = 0; sat = 0; shamt = '0; in = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name, input logic [3:0] eo, input logic ec,
                               input logic eb, input logic ed);
        check({name, ".out"},   32'(out),   32'(eo));
        check({name, ".carry"}, 32'(carry), 32'(ec));
        check({name, ".zero"},  32'(zero),  32'(eo == 4'b0000));
        check({name, ".busy"},  32'(busy),  32'(eb));
        check({name, ".done"},  32'(done),  32'(ed));
    endtask

    task automatic load(input logic [3:0] v);
        idle_inputs();
        ld = 1; in = v;
        tick();
        idle_inputs();
    endtask

    initial begin
        int n;
        //          cl ld inc dec sr sl ir il rot sat shamt  din      e_out    c  b  d
        vec[0]  = '{'0,'1,'0,'0,'0,'0,'0,'0,'0,'0, 3'd0, 4'b1011, 4'b1011, '0,'0,'0};
        vec[1]  = '{'1,'0,'0,'0,'0,'0,'0,'0,'0,'0, 3'd0, 4'b0000, 4'b0000, '0,'0,'0};
        vec[2]  = '{'0,'1,'0,'0,'0,'0,'0,'0,'0,'0, 3'd0, 4'b1111, 4'b1111, '0,'0,'0};
        vec[3]  = '{'0,'0,'1,'0,'0,'0,'0,'0,'0,'0, 3'd0, 4'b0000, 4'b0000, '1,'0,'0};
        vec[4]  = '{'0,'1,'0,'0,'0,'0,'0,'0,'0,'0, 3'd0, 4'b1111, 4'b1111, '1,'0,'0};
        vec[5]  = '{'0,'0,'1,'0,'0,'0,'0,'0,'0,'1, 3'd0, 4'b0000, 4'b1111, '1,'0,'0};
        vec[6]  = '{'1,'0,'0,'0,'0,'0,'0,'0,'0,'0, 3'd0, 4'b0000, 4'b0000, '0,'0,'0};
        vec[7]  = '{'0,'0,'0,'1,'0,'0,'0,'0,'0,'0, 3'd0, 4'b0000, 4'b1111, '1,'0,'0};
        vec[8]  = '{'1,'0,'0,'0,'0,'0,'0,'0,'0,'0, 3'd0, 4'b0000, 4'b0000, '0,'0,'0};
        vec[9]  = '{'0,'0,'0,'1,'0,'0,'0,'0,'0,'1, 3'd0, 4'b0000, 4'b0000, '1,'0,'0};
        vec[10] = '{'0,'0,'1,'0,'0,'0,'0,'0,'0,'0, 3'd0, 4'b0000, 4'b0001, '0,'0,'0};
        vec[11] = '{'0,'0,'0,'1,'0,'0,'0,'0,'0,'0, 3'd0, 4'b0000, 4'b0000, '0,'0,'0};
        vec[12] = '{'0,'1,'0,'0,'0,'0,'0,'0,'0,'0, 3'd0, 4'b0110, 4'b0110, '0,'0,'0};
        vec[13] = '{'1,'1,'1,'0,'1,'0,'0,'0,'0,'0, 3'd3, 4'b1010, 4'b0000, '0,'0,'0};
        vec[14] = '{'0,'1,'0,'0,'0,'0,'0,'0,'0,'0, 3'd0, 4'b0110, 4'b0110, '0,'0,'0};
        vec[15] = '{'0,'0,'1,'1,'0,'0,'0,'0,'0,'0, 3'd0, 4'b0000, 4'b0111, '0,'0,'0};
        vec[16] = '{'0,'0,'0,'0,'1,'0,'1,'0,'0,'0, 3'd0, 4'b0000, 4'b0111, '0,'0,'0};
        vec[17] = '{'0,'0,'0,'0,'1,'0,'0,'0,'0,'0, 3'd1, 4'b0000, 4'b0011, '1,'0,'1};
        vec[18] = '{'0,'0,'0,'0,'0,'1,'0,'1,'1,'0, 3'd1, 4'b0000, 4'b0110, '0,'0,'1};
        vec[19] = '{'0,'0,'0,'0,'0,'1,'0,'1,'0,'0, 3'd1, 4'b0000, 4'b1101, '0,'0,'1};
        vec[20] = '{'0,'0,'0,'0,'0,'0,'0,'0,'0,'0, 3'd0, 4'b0000, 4'b1101, '0,'0,'0};
        vec[21] = '{'0,'0,'0,'0,'1,'1,'0,'1,'0,'0, 3'd1, 4'b0000, 4'b0110, '1,'0,'1};
        vec[22] = '{'0,'1,'0,'0,'0,'0,'0,'0,'0,'0, 3'd0, 4'b1000, 4'b1000, '1,'0,'0};
        vec[23] = '{'0,'0,'0,'1,'0,'0,'0,'0,'0,'1, 3'd0, 4'b0000, 4'b0111, '0,'0,'0};

        idle_inputs();
        rst_n = 0;
        #3;
        check_state("reset", 4'b0000, 0, 0, 0);
        @(negedge clk);
        rst_n = 1;
        tick();

        for (int i = 0; i < 24; i++) begin
            cl = vec[i].cl;   ld = vec[i].ld;   inc = vec[i].inc; dec = vec[i].dec;
            sr = vec[i].sr;   sl = vec[i].sl;   ir = vec[i].ir;   il = vec[i].il;
            rot = vec[i].rot; sat = vec[i].sat; shamt = vec[i].shamt; in = vec[i].din;
            tick();
            check_state($sformatf("vec%0d", i), vec[i].e_out, vec[i].e_carry,
                        vec[i].e_busy, vec[i].e_done);
        end
        idle_inputs();

        // sr by 3, ir held high
        load(4'b1001);
        sr = 1; shamt = 3'd3; ir = 1;
        tick();
        sr = 0; shamt = '0;
        check_state("sr3.s1", 4'b1100, 1, 1, 0);
        tick();
        check_state("sr3.s2", 4'b1110, 0, 1, 0);
        tick();
        check_state("sr3.s3", 4'b1111, 0, 0, 1);
        tick();
        check_state("sr3.post", 4'b1111, 0, 0, 0);
        idle_inputs();

        // sl rotate by 5 with ld/inc noise mid-shift
        load(4'b1001);
        sl = 1; rot = 1; shamt = 3'd5;
        tick();
        idle_inputs();
        check_state("rol5.s1", 4'b0011, 1, 1, 0);
        ld = 1; inc = 1; in = 4'b0000; sr = 1; shamt = 3'd2;
        tick();
        tick();
        idle_inputs();
        check_state("rol5.s3", 4'b1100, 0, 1, 0);
        tick();
        tick();
        check_state("rol5.s5", 4'b0011, 1, 0, 1);

        // sr by 6 aborted by cl
        load(4'b1010);
        sr = 1; shamt = 3'd6;
        tick();
        idle_inputs();
        tick();
        check_state("abort.s2", 4'b0010, 1, 1, 0);
        cl = 1;
        tick();
        cl = 0;
        check_state("abort.cl", 4'b0000, 0, 0, 0);
        tick();
        check_state("abort.post", 4'b0000, 0, 0, 0);

        // shift of 7 exceeds width: everything shifted out, timed by done
        load(4'b1111);
        sr = 1; shamt = 3'd7;
        tick();
        idle_inputs();
        n = 1;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check("sr7.cycles", 32'(n), 32'd7);
        check_state("sr7.end", 4'b0000, 0, 0, 1);

        // asynchronous reset mid-shift
        load(4'b1010);
        sr = 1; shamt = 3'd6;
        tick();
        idle_inputs();
        tick();
        #2;
        rst_n = 0;
        #1;
        check_state("arst", 4'b0000, 0, 0, 0);
        @(negedge clk);
        rst_n = 1;
        tick();
        check_state("arst.post", 4'b0000, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
